// File: rtl/uart_packet_framer_if.sv
// Structures package and byte/packet bus for the UART packet framer.
//
// Structures::UART_PACKET is one framed beat: the header fields of the
// current packet, SoP/EoP markers, one payload byte and a Valid strobe.
//
// uart_packet_framer_if groups the raw RX byte strobe with the framed
// output stream and the drop reporting signals:
//   ipRxData     8            received byte from the UART RX
//   ipRxValid    1            one-cycle strobe, ipRxData valid this cycle
//   opRxStream   UART_PACKET  framed packet stream
//   opAbort      1            one-cycle pulse when a frame is dropped
//   opDropCount  8            saturating count of dropped frames
// The master modport is the byte source / stream consumer side, the
// slave modport is the framer itself.

package Structures;

   typedef struct packed {
      logic [7:0] source;
      logic [7:0] destination;
      logic [7:0] length;
      logic       sop;
      logic       eop;
      logic [7:0] data;
      logic       valid;
   } UART_PACKET;

endpackage

interface uart_packet_framer_if;
   import Structures::*;

   logic [7:0] ipRxData;
   logic       ipRxValid;
   UART_PACKET opRxStream;
   logic       opAbort;
   logic [7:0] opDropCount;

   modport master (
      output ipRxData, ipRxValid,
      input  opRxStream, opAbort, opDropCount
   );

   modport slave (
      input  ipRxData, ipRxValid,
      output opRxStream, opAbort, opDropCount
   );
endinterface

// File: rtl/uart_packet_framer.sv
// uart_packet_framer
//
// Parses raw UART RX bytes into framed UART_PACKET beats. A frame is
// SYNC, Destination, Source, Length, then Length payload bytes. Each
// payload byte produces one registered Valid beat one cycle after its
// strobe, with SoP on the first and EoP on the last. Frames with a bad
// length or that stall longer than TIMEOUT_CYCLES between bytes are
// dropped with an opAbort pulse and counted in opDropCount.
//
// Ports:
//   ipClk    in  1   system clock, rising edge
//   ipReset  in  1   asynchronous, active-high reset
//   rxBus    slave modport of uart_packet_framer_if (RX bytes in,
//            framed stream, abort pulse and drop count out)

module uart_packet_framer #(
   parameter logic [7:0] SYNC_BYTE      = 8'h55,
   parameter int         MAX_LENGTH     = 8,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input  logic                  ipClk,
   input  logic                  ipReset,
   uart_packet_framer_if.slave   rxBus
);

   localparam int         CW           = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] MAX_LEN      = 8'(MAX_LENGTH);

   typedef enum logic [2:0] {
      IDLE,
      DEST,
      SRC,
      LEN,
      DATA
   } FramerState;

   FramerState             state;
   FramerState             nextState;
   logic [CW-1:0]          timeoutCount;
   logic [7:0]             remaining;
   logic                   firstBeat;
   logic [7:0]             destReg;
   logic [7:0]             srcReg;
   Structures::UART_PACKET streamReg;
   logic                   abortReg;
   logic [7:0]             dropCount;

   logic                   lenAccept;
   logic                   lenDrop;
   logic                   beat;
   logic                   lastBeat;
   logic                   timeoutHit;

   assign rxBus.opRxStream  = streamReg;
   assign rxBus.opAbort     = abortReg;
   assign rxBus.opDropCount = dropCount;

   // State register for the header/payload parser.
   always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode. The parser only moves on a byte strobe, except for
   // the timeout, which forces a return to IDLE when the frame has been
   // silent too long. A byte arriving on the timeout cycle takes priority,
   // which is why the timeout is qualified with the strobe being low.
   always_comb begin
      nextState  = state;
      lenAccept  = 1'b0;
      lenDrop    = 1'b0;
      beat       = 1'b0;
      lastBeat   = 1'b0;
      timeoutHit = 1'b0;
      case (state)
         IDLE: begin
            if (rxBus.ipRxValid && rxBus.ipRxData == SYNC_BYTE) begin
               nextState = DEST;
            end
         end
         DEST: begin
            if (rxBus.ipRxValid) begin
               nextState = SRC;
            end
         end
         SRC: begin
            if (rxBus.ipRxValid) begin
               nextState = LEN;
            end
         end
         LEN: begin
            if (rxBus.ipRxValid) begin
               if (rxBus.ipRxData == 8'd0 || rxBus.ipRxData > MAX_LEN) begin
                  lenDrop   = 1'b1;
                  nextState = IDLE;
               end else begin
                  lenAccept = 1'b1;
                  nextState = DATA;
               end
            end
         end
         DATA: begin
            if (rxBus.ipRxValid) begin
               beat = 1'b1;
               if (remaining == 8'd1) begin
                  lastBeat  = 1'b1;
                  nextState = IDLE;
               end
            end
         end
         default: nextState = IDLE;
      endcase
      if (state != IDLE && !rxBus.ipRxValid && timeoutCount == TIMEOUT_LAST) begin
         timeoutHit = 1'b1;
         nextState  = IDLE;
      end
   end

   // Inter-byte silence counter. It only runs while a frame is open and is
   // cleared by every byte and by leaving the frame, so each new frame
   // starts with a full timeout budget.
   always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
         timeoutCount <= '0;
      end else if (state == IDLE || rxBus.ipRxValid || timeoutHit) begin
         timeoutCount <= '0;
      end else begin
         timeoutCount <= timeoutCount + 1'b1;
      end
   end

   // Header capture and output stream registers. Destination and Source are
   // held privately until the length is accepted so a rejected header never
   // disturbs the fields of the last good packet on the output.
   always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
         destReg   <= '0;
         srcReg    <= '0;
         remaining <= '0;
         firstBeat <= 1'b0;
         streamReg <= '0;
         abortReg  <= 1'b0;
         dropCount <= '0;
      end else begin
         streamReg.valid <= beat;
         streamReg.sop   <= beat && firstBeat;
         streamReg.eop   <= lastBeat;
         abortReg        <= lenDrop || timeoutHit;
         if ((lenDrop || timeoutHit) && dropCount != 8'hFF) begin
            dropCount <= dropCount + 8'd1;
         end
         if (rxBus.ipRxValid && state == DEST) begin
            destReg <= rxBus.ipRxData;
         end
         if (rxBus.ipRxValid && state == SRC) begin
            srcReg <= rxBus.ipRxData;
         end
         if (lenAccept) begin
            streamReg.destination <= destReg;
            streamReg.source      <= srcReg;
            streamReg.length      <= rxBus.ipRxData;
            remaining             <= rxBus.ipRxData;
            firstBeat             <= 1'b1;
         end
         if (beat) begin
            streamReg.data <= rxBus.ipRxData;
            remaining      <= remaining - 8'd1;
            firstBeat      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_packet_framer.sv
// tb_uart_packet_framer
//
// Bench for uart_packet_framer. A fixed vector table covers the basic
// frame, length errors and sync-as-payload; hand-written sequences cover
// noise, timeout, async reset and drop-count saturation; a random phase
// checks every cycle against a queue-based frame model.

module tb_uart_packet_framer;

   localparam logic [7:0] SYNC = 8'h55;
   localparam int         MAXL = 8;
   localparam int         TO   = 16;

   logic ipClk;
   logic ipReset;

   uart_packet_framer_if bus ();

   uart_packet_framer #(
      .SYNC_BYTE      (SYNC),
      .MAX_LENGTH     (MAXL),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .ipClk   (ipClk),
      .ipReset (ipReset),
      .rxBus   (bus.slave)
   );

   // Free-running clock, 10 time units per cycle.
   initial ipClk = 1'b0;
   always #5 ipClk = ~ipClk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: collects the header bytes of the open frame in a
   // queue, counts payload still owed and idle cycles since the last byte.
   logic [7:0] hdr[$];
   int         owed;
   bit         first;
   int         idle;
   logic       eValid, eSop, eEop, eAbort;
   logic [7:0] eData, eDst, eSrc, eLen, eDrop;

   task automatic modelReset();
      hdr.delete();
      owed   = 0;
      first  = 0;
      idle   = 0;
      eValid = 0; eSop = 0; eEop = 0; eAbort = 0;
      eData  = 0; eDst = 0; eSrc = 0; eLen = 0; eDrop = 0;
   endtask

   task automatic modelDrop();
      eAbort = 1;
      if (eDrop != 8'hFF) eDrop = eDrop + 8'd1;
      hdr.delete();
      idle = 0;
   endtask

   task automatic modelStep(input logic v, input logic [7:0] d);
      bit inFrame;
      eValid = 0; eSop = 0; eEop = 0; eAbort = 0;
      inFrame = (hdr.size() > 0);
      if (v) begin
         idle = 0;
         if (hdr.size() == 0) begin
            if (d == SYNC) hdr.push_back(d);
         end else if (hdr.size() < 4) begin
            hdr.push_back(d);
            if (hdr.size() == 4) begin
               if (d == 0 || int'(d) > MAXL) modelDrop();
               else begin
                  owed  = int'(d);
                  first = 1;
               end
            end
         end else begin
            eValid = 1;
            eData  = d;
            eSop   = first;
            first  = 0;
            eDst   = hdr[1];
            eSrc   = hdr[2];
            eLen   = hdr[3];
            owed   = owed - 1;
            if (owed == 0) begin
               eEop = 1;
               hdr.delete();
            end
         end
      end else if (inFrame) begin
         idle = idle + 1;
         if (idle == TO) modelDrop();
      end
   endtask

   // Drive one cycle of input, advance the model, and land 1 unit after
   // the active edge where the registered outputs are stable.
   task automatic applyStimulus(input logic v, input logic [7:0] d);
      bus.ipRxValid = v;
      bus.ipRxData  = d;
      modelStep(v, d);
      @(posedge ipClk);
      #1;
   endtask

   function automatic logic [43:0] packAct(input logic withFields);
      return {bus.opRxStream.valid, bus.opRxStream.sop, bus.opRxStream.eop,
              bus.opAbort, bus.opDropCount,
              withFields ? {bus.opRxStream.data, bus.opRxStream.destination,
                            bus.opRxStream.source, bus.opRxStream.length} : 32'h0};
   endfunction

   task automatic compare(input string name, input logic [43:0] act, input logic [43:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s t=%0t vld/sop/eop/abt/drop/data/dst/src/len actual=%h required=%h",
                  name, $time, act, exp);
      end
   endtask

   task automatic checkOutput(input string name);
      compare(name, packAct(eValid),
              {eValid, eSop, eEop, eAbort, eDrop,
               eValid ? {eData, eDst, eSrc, eLen} : 32'h0});
   endtask

   task automatic cycleChecked(input logic v, input logic [7:0] d, input string name);
      applyStimulus(v, d);
      checkOutput(name);
   endtask

   task automatic sendFrame(input logic [7:0] dst, input logic [7:0] src,
                            input logic [7:0] len, input string name);
      cycleChecked(1, SYNC, name);
      cycleChecked(1, dst, name);
      cycleChecked(1, src, name);
      cycleChecked(1, len, name);
   endtask

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       eV, eS, eE, eA;
      logic [7:0] eData, eDst, eSrc, eLen, eDrop;
   } TableRow;

   function automatic TableRow mkRow(input logic v, input logic [7:0] d,
                                     input logic eV, input logic eS, input logic eE,
                                     input logic eA, input logic [7:0] eData,
                                     input logic [7:0] eDst, input logic [7:0] eSrc,
                                     input logic [7:0] eLen, input logic [7:0] eDrop);
      TableRow r;
      r.v = v; r.d = d; r.eV = eV; r.eS = eS; r.eE = eE; r.eA = eA;
      r.eData = eData; r.eDst = eDst; r.eSrc = eSrc; r.eLen = eLen; r.eDrop = eDrop;
      return r;
   endfunction

   TableRow vecTable[$];

   initial begin
      int abortSeen;
      int eopSeen;
      logic [7:0] dropBefore;

      // T1: normal frame, 4 beats
      vecTable.push_back(mkRow(1, 8'h55, 0,0,0,0, 0,0,0,0, 0));
      vecTable.push_back(mkRow(1, 8'h00, 0,0,0,0, 0,0,0,0, 0));
      vecTable.push_back(mkRow(1, 8'h07, 0,0,0,0, 0,0,0,0, 0));
      vecTable.push_back(mkRow(1, 8'h04, 0,0,0,0, 0,0,0,0, 0));
      vecTable.push_back(mkRow(1, 8'hAA, 1,1,0,0, 8'hAA,8'h00,8'h07,8'h04, 0));
      vecTable.push_back(mkRow(1, 8'hBB, 1,0,0,0, 8'hBB,8'h00,8'h07,8'h04, 0));
      vecTable.push_back(mkRow(1, 8'hCC, 1,0,0,0, 8'hCC,8'h00,8'h07,8'h04, 0));
      vecTable.push_back(mkRow(1, 8'hDD, 1,0,1,0, 8'hDD,8'h00,8'h07,8'h04, 0));
      vecTable.push_back(mkRow(0, 8'h00, 0,0,0,0, 0,0,0,0, 0));
      // T3: Len=0 then Len=9 dropped, then a good frame
      vecTable.push_back(mkRow(1, 8'h55, 0,0,0,0, 0,0,0,0, 0));
      vecTable.push_back(mkRow(1, 8'h00, 0,0,0,0, 0,0,0,0, 0));
      vecTable.push_back(mkRow(1, 8'h00, 0,0,0,0, 0,0,0,0, 0));
      vecTable.push_back(mkRow(1, 8'h00, 0,0,0,1, 0,0,0,0, 1));
      vecTable.push_back(mkRow(1, 8'h55, 0,0,0,0, 0,0,0,0, 1));
      vecTable.push_back(mkRow(1, 8'h00, 0,0,0,0, 0,0,0,0, 1));
      vecTable.push_back(mkRow(1, 8'h00, 0,0,0,0, 0,0,0,0, 1));
      vecTable.push_back(mkRow(1, 8'h09, 0,0,0,1, 0,0,0,0, 2));
      vecTable.push_back(mkRow(1, 8'h55, 0,0,0,0, 0,0,0,0, 2));
      vecTable.push_back(mkRow(1, 8'h01, 0,0,0,0, 0,0,0,0, 2));
      vecTable.push_back(mkRow(1, 8'h02, 0,0,0,0, 0,0,0,0, 2));
      vecTable.push_back(mkRow(1, 8'h08, 0,0,0,0, 0,0,0,0, 2));
      for (int k = 0; k < 8; k++) begin
         vecTable.push_back(mkRow(1, 8'(8'h30 + k), 1, k == 0, k == 7, 0,
                                  8'(8'h30 + k), 8'h01, 8'h02, 8'h08, 2));
      end
      // T5: sync value as payload, no resync
      vecTable.push_back(mkRow(1, 8'h55, 0,0,0,0, 0,0,0,0, 2));
      vecTable.push_back(mkRow(1, 8'h00, 0,0,0,0, 0,0,0,0, 2));
      vecTable.push_back(mkRow(1, 8'h01, 0,0,0,0, 0,0,0,0, 2));
      vecTable.push_back(mkRow(1, 8'h02, 0,0,0,0, 0,0,0,0, 2));
      vecTable.push_back(mkRow(1, 8'h55, 1,1,0,0, 8'h55,8'h00,8'h01,8'h02, 2));
      vecTable.push_back(mkRow(1, 8'h55, 1,0,1,0, 8'h55,8'h00,8'h01,8'h02, 2));
      vecTable.push_back(mkRow(0, 8'h00, 0,0,0,0, 0,0,0,0, 2));

      // Reset state
      ipReset       = 1'b1;
      bus.ipRxValid = 1'b0;
      bus.ipRxData  = 8'h00;
      modelReset();
      #12;
      compare("reset", packAct(1'b1), 44'h0);
      @(posedge ipClk);
      #1;
      ipReset = 1'b0;

      foreach (vecTable[i]) begin
         applyStimulus(vecTable[i].v, vecTable[i].d);
         compare($sformatf("table[%0d]", i), packAct(vecTable[i].eV),
                 {vecTable[i].eV, vecTable[i].eS, vecTable[i].eE, vecTable[i].eA,
                  vecTable[i].eDrop,
                  vecTable[i].eV ? {vecTable[i].eData, vecTable[i].eDst,
                                    vecTable[i].eSrc, vecTable[i].eLen} : 32'h0});
      end

      // T2: noise before sync
      cycleChecked(1, 8'h12, "t2Noise");
      cycleChecked(1, 8'h34, "t2Noise");
      sendFrame(8'h01, 8'h02, 8'h01, "t2Hdr");
      cycleChecked(1, 8'h9C, "t2Beat");
      compare("t2Drop", {36'h0, bus.opDropCount}, 44'd2);

      // T4: stall after 2 of 4 payload bytes
      dropBefore = eDrop;
      abortSeen  = 0;
      eopSeen    = 0;
      sendFrame(8'h03, 8'h04, 8'h04, "t4Hdr");
      cycleChecked(1, 8'h11, "t4Beat");
      cycleChecked(1, 8'h22, "t4Beat");
      for (int k = 0; k < TO + 3; k++) begin
         cycleChecked(0, 8'h00, "t4Idle");
         if (bus.opAbort) abortSeen++;
         if (bus.opRxStream.eop) eopSeen++;
      end
      compare("t4Abort", {32'h0, 12'(abortSeen)}, 44'd1);
      compare("t4NoEop", {32'h0, 12'(eopSeen)}, 44'd0);
      compare("t4Drop", {36'h0, bus.opDropCount}, {36'h0, dropBefore + 8'd1});
      sendFrame(8'h05, 8'h06, 8'h01, "t4After");
      cycleChecked(1, 8'h77, "t4After");

      // Byte arriving exactly on the timeout cycle wins
      sendFrame(8'h03, 8'h04, 8'h02, "toEdge");
      cycleChecked(1, 8'h11, "toEdge");
      for (int k = 0; k < TO - 1; k++) cycleChecked(0, 8'h00, "toEdgeIdle");
      cycleChecked(1, 8'h22, "toEdgeByte");
      compare("toEdgeEop", {43'h0, bus.opRxStream.eop}, 44'd1);
      cycleChecked(0, 8'h00, "toEdgeIdle");

      // T6: async reset mid-DATA clears outputs without a clock edge
      sendFrame(8'h00, 8'h07, 8'h04, "t6Hdr");
      cycleChecked(1, 8'hAA, "t6Beat");
      bus.ipRxValid = 1'b0;
      #2;
      ipReset = 1'b1;
      #1;
      compare("asyncReset", packAct(1'b1), 44'h0);
      modelReset();
      @(posedge ipClk);
      #1;
      ipReset = 1'b0;
      cycleChecked(1, 8'hBB, "t6Post");
      sendFrame(8'h01, 8'h02, 8'h01, "t6Post");
      cycleChecked(1, 8'h9C, "t6Post");

      // Random frames with noise, bad lengths and occasional stalls
      for (int f = 0; f < 80; f++) begin
         int len;
         int stallAt;
         int sel;
         for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
            cycleChecked(1, 8'($urandom_range(0, 255)), "randNoise");
         end
         sel = int'($urandom_range(0, 9));
         if (sel == 0) len = 0;
         else if (sel == 1) len = int'($urandom_range(9, 255));
         else len = int'($urandom_range(1, MAXL));
         stallAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
         for (int b = 0; b < 4 + ((len >= 1 && len <= MAXL) ? len : 0); b++) begin
            logic [7:0] d;
            int gap;
            if (b == 0) d = SYNC;
            else if (b == 3) d = 8'(len);
            else if ($urandom_range(0, 5) == 0) d = SYNC;
            else d = 8'($urandom_range(0, 255));
            gap = (b == stallAt) ? int'($urandom_range(TO - 2, TO + 1))
                                 : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) cycleChecked(0, 8'h00, "randGap");
            cycleChecked(1, d, "rand");
         end
      end

      // Saturation of the drop counter
      for (int k = 0; k < 300; k++) begin
         sendFrame(8'h00, 8'h00, 8'h00, "satDrop");
      end
      compare("dropSat", {36'h0, bus.opDropCount}, {36'h0, 8'hFF});
      cycleChecked(0, 8'h00, "satIdle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog t=%0t actual=running required=finished", $time);
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
